// File: rtl/div_seq_pkg.sv
// Shared encodings for the divide sequencer and the single-cycle ALU it borrows.
// One-hot bit positions, divide opcodes and sequencer states live here.
package div_seq_pkg;

  localparam int OPC_W = 10;
  localparam int ALU_W = 10;
  localparam int BR_W  = 6;

  localparam int OPC_ALU = 8;

  localparam int ALU_ADD = 9;
  localparam int ALU_SUB = 8;
  localparam int ALU_AND = 0;

  localparam int BR_BEQ  = 5;
  localparam int BR_BGEU = 0;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_signed_op(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_special.sv
// Detects divide-by-zero and signed overflow (MIN / -1) and supplies the
// architecturally defined result so the sequencer can skip the iterations.
module div_special
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  div_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             special,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic div_zero;
  logic overflow;

  always_comb begin
    div_zero = (b == '0);
    overflow = is_signed_op(op) && (a == MIN_NEG) && (b == '1);
    special  = div_zero | overflow;
    result   = '0;
    if (div_zero) begin
      result = is_rem_op(op) ? a : '1;
    end else if (overflow) begin
      result = is_rem_op(op) ? '0 : MIN_NEG;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Restoring divider that performs one step per cycle on the shared ALU's
// subtractor and unsigned compare; owns the ALU only while iterating.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_data_o,
  output logic             alu_busy_o,
  output logic [OPC_W-1:0] alu_opcode_o,
  output logic [ALU_W-1:0] alu_info_o,
  output logic [BR_W-1:0]  alu_branch_o,
  output logic [WIDTH-1:0] alu_rs1_o,
  output logic [WIDTH-1:0] alu_rs2_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_branch_jump_i
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_next;
  div_op_e          req_op, op;
  logic [WIDTH-1:0] dividend, divisor, rem, quot;
  logic [CW-1:0]    count;
  logic             q_sign, r_sign;
  logic             accept, req_signed;
  logic             special;
  logic [WIDTH-1:0] special_result;
  logic             rc, q_bit;
  logic [WIDTH-1:0] rem_shift, fix_raw, fix_value;

  assign req_op       = div_op_e'(req_op_i);
  assign req_signed   = is_signed_op(req_op);
  assign req_ready_o  = (state == S_IDLE) & ~rst;
  assign accept       = req_valid_i & req_ready_o & ~flush_i;
  assign resp_valid_o = (state == S_DONE);

  div_special #(.WIDTH(WIDTH)) u_special (
    .op     (req_op),
    .a      (req_a_i),
    .b      (req_b_i),
    .special(special),
    .result (special_result)
  );

  // rc is the bit shifted out of R; when set, R' + 2^WIDTH certainly exceeds |b|.
  always_comb begin
    rc        = rem[WIDTH-1];
    rem_shift = {rem[WIDTH-2:0], dividend[count]};
    q_bit     = rc | alu_branch_jump_i;
    fix_raw   = is_rem_op(op) ? rem : quot;
    fix_value = (is_rem_op(op) ? r_sign : q_sign) ? -fix_raw : fix_raw;
  end

  always_comb begin
    alu_busy_o   = 1'b0;
    alu_opcode_o = '0;
    alu_info_o   = '0;
    alu_branch_o = '0;
    alu_rs1_o    = '0;
    alu_rs2_o    = '0;
    if (state == S_ITER) begin
      alu_busy_o            = 1'b1;
      alu_opcode_o[OPC_ALU] = 1'b1;
      alu_info_o[ALU_SUB]   = 1'b1;
      alu_branch_o[BR_BGEU] = 1'b1;
      alu_rs1_o             = rem_shift;
      alu_rs2_o             = divisor;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept) state_next = special ? S_DONE : S_ITER;
      S_ITER: if (count == '0) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (resp_ready_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush_i) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= OP_DIV;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quot        <= '0;
      count       <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      resp_data_o <= '0;
    end else if (accept) begin
      op       <= req_op;
      dividend <= (req_signed && req_a_i[WIDTH-1]) ? -req_a_i : req_a_i;
      divisor  <= (req_signed && req_b_i[WIDTH-1]) ? -req_b_i : req_b_i;
      rem      <= '0;
      quot     <= '0;
      count    <= CW'(WIDTH - 1);
      q_sign   <= req_signed & (req_a_i[WIDTH-1] ^ req_b_i[WIDTH-1]);
      r_sign   <= req_signed & req_a_i[WIDTH-1];
      if (special) resp_data_o <= special_result;
    end else if (!flush_i && state == S_ITER) begin
      rem   <= q_bit ? alu_result_i : rem_shift;
      quot  <= {quot[WIDTH-2:0], q_bit};
      count <= count - 1'b1;
    end else if (!flush_i && state == S_FIX) begin
      resp_data_o <= fix_value;
    end
  end

endmodule
